muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle multiply/divide unit in the EX stage. It produces the 64-bit {hi, lo} result and the one-cycle hi/lo write strobe. These travel down the pipeline and are finally consumed by the hi/lo write port of the ID-stage register file. The unit accepts one MULT/MULTU/DIV/DIVU at a time, stalls the front end through `busy` while it iterates, and can be aborted by an exception flush.

## Interface

Parameters:
- none (32-bit datapath fixed)

Ports:
- `clk`  in  1  clock; single clock domain, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request to begin the operation in `op`; sampled only in IDLE or DONE
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `src_a`  in  32  multiplicand / dividend; sampled with `start`
- `src_b`  in  32  multiplier / divisor; sampled with `start`
- `flush`  in  1  abort any operation; no result is written
- `busy`  out  1  stall request to ID/EX; combinational
- `hl_write_enable`  out  1  one-cycle strobe: `hl_data` is a new valid result
- `hl_data`  out  64  {hi, lo}; MULT*: full product; DIV*: {remainder, quotient}

## Operation

- States: IDLE, MUL, DIV, DONE. Reset: state IDLE, `hl_data`=0, `hl_write_enable`=0, iteration counter 0.
- Accept: state IDLE or DONE, `start`=1, `flush`=0.
  - Latch |src_a|, |src_b| (absolute value only for signed ops), sign_a, sign_b, op.
  - Go to MUL (op[1]=0) or DIV (op[1]=1).
  - Otherwise IDLE stays IDLE and DONE returns to IDLE.
- MUL: form the 64-bit unsigned product of the magnitudes. Negate (two's complement, 64-bit) if signed and sign_a^sign_b. Register into `hl_data`. Go to DONE.
- DIV: restoring radix-2 division, one quotient bit per cycle, 32 cycles, counter 0..31.
  - Each cycle: shift the remainder left, bring in the next dividend bit, subtract the divisor if no borrow, set the quotient bit.
  - After counter 31: apply signs and register `hl_data`. Quotient is negated if sign_a^sign_b. Remainder is negated if sign_a (remainder takes the dividend's sign). Go to DONE.
- Divide by zero: runs the full 32 cycles, no trap. Result is `hl_data` = {src_a as latched, 32'hFFFFFFFF} for both DIV and DIVU, with no sign correction.
- 0x80000000 / 0xFFFFFFFF (DIV): quotient 0x80000000, remainder 0, no trap.
- DONE: `hl_write_enable`=1 for exactly this cycle. `hl_data` holds its value until the next result or reset.
- `busy` = (state==MUL) | (state==DIV) | ((state==IDLE | state==DONE) & `start` & ~`flush`).
- `flush` in any state: next state IDLE, counter cleared, `hl_data` unchanged.
  - `flush` in DONE: this cycle's strobe is suppressed (`hl_write_enable` = ~`flush` in DONE).
  - `flush` and `start` in the same cycle: `flush` wins, nothing is accepted.
- `start` in MUL/DIV: ignored. Operand changes after acceptance: ignored.
- `rst` overrides everything, including `flush` and `start`.

## Timing

- `start` sampled at edge T. The edges below bound each state.
- MULT/MULTU:
  - MUL between edges T and T+1.
  - DONE between edges T+1 and T+2; `hl_write_enable` high only in that cycle.
  - Latency 2 cycles.
- DIV/DIVU:
  - DIV from edge T to edge T+32.
  - DONE between edges T+32 and T+33.
  - Latency 33 cycles.
- `busy` high from the request cycle through the last MUL/DIV cycle. It is low in DONE unless a new request is accepted there.
- Back-to-back: a `start` in the DONE cycle is accepted at that edge; there are no idle cycles between results.
- `hl_data` updates at the edge entering DONE and is stable for the whole DONE cycle.

## Test plan

- After reset: `busy`=0, `hl_write_enable`=0, `hl_data`=0.
- MULT a=0xFFFFFFFE (-2), b=0x00000003 -> 2 cycles later strobe with `hl_data`=0xFFFFFFFF_FFFFFFFA. MULTU with the same operands -> 0x00000002_FFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 -> `busy` high for 33 cycles, then strobe with hi=0xFFFFFFFF (-1), lo=0xFFFFFFFD (-3). DIVU a=7, b=2 -> hi=1, lo=3.
- DIVU a=0x12345678, b=0 -> strobe at T+33 with `hl_data`=0x12345678_FFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> hi=0, lo=0x80000000.
- DIV started, `flush` asserted in cycle 10 -> `busy` low the next cycle, no strobe ever, `hl_data` keeps the prior result. A new MULT issued immediately afterwards completes normally.
- MULT, then a DIVU with `start` held in the DONE cycle -> MULT strobe in that cycle and DIVU accepted at the same edge. The DIVU strobe comes 33 cycles later. A `start`+`flush` pair in IDLE is not accepted.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit for the EX stage.
// A multiply takes one MUL cycle. A divide takes 32 restoring radix-2 cycles.
// Either kind then spends one DONE cycle, where hl_write_enable strobes {hi, lo}.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic        hl_write_enable,
  output logic [63:0] hl_data
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  count_reg;
  logic [31:0] mag_a_reg, mag_b_reg;
  logic        sign_a_reg, sign_b_reg;
  logic [31:0] rem_reg, quo_reg;
  logic [63:0] hl_data_reg;

  logic        accept;
  logic        in_sign_a, in_sign_b;
  logic [31:0] in_mag_a, in_mag_b;
  logic [32:0] shifted, diff;
  logic [31:0] rem_step, quo_step;
  logic [63:0] product;
  logic        neg_result;

  // A new operation is taken only from IDLE/DONE, and flush always wins over start.
  assign accept = (state_reg == IDLE || state_reg == DONE) && start && !flush;

  // Operand conditioning: signed ops work on magnitudes and fix the signs at the end.
  assign in_sign_a = !op[0] && src_a[31];
  assign in_sign_b = !op[0] && src_b[31];
  assign in_mag_a  = in_sign_a ? (32'd0 - src_a) : src_a;
  assign in_mag_b  = in_sign_b ? (32'd0 - src_b) : src_b;

  // One restoring step. The dividend is shifted out of the top of quo_reg while
  // quotient bits enter at the bottom. Bit 32 of diff is the borrow.
  assign shifted    = {rem_reg, quo_reg[31]};
  assign diff       = shifted - {1'b0, mag_b_reg};
  assign rem_step   = diff[32] ? shifted[31:0] : diff[31:0];
  assign quo_step   = {quo_reg[30:0], ~diff[32]};
  assign product    = mag_a_reg * mag_b_reg;
  assign neg_result = sign_a_reg ^ sign_b_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic, busy (stall) and the DONE-cycle write strobe.
  always_comb begin
    state_next      = state_reg;
    busy            = 1'b0;
    hl_write_enable = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = accept;
        if (accept) state_next = op[1] ? DIV : MUL;
      end
      MUL: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DIV: begin
        busy = 1'b1;
        if (count_reg == 5'd31) state_next = DONE;
      end
      DONE: begin
        busy            = accept;
        hl_write_enable = !flush;
        if (accept) state_next = op[1] ? DIV : MUL;
        else        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Datapath: latch operands, iterate the divider, and register the final {hi, lo}.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg   <= 5'd0;
      mag_a_reg   <= 32'd0;
      mag_b_reg   <= 32'd0;
      sign_a_reg  <= 1'b0;
      sign_b_reg  <= 1'b0;
      rem_reg     <= 32'd0;
      quo_reg     <= 32'd0;
      hl_data_reg <= 64'd0;
    end else if (flush) begin
      count_reg <= 5'd0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            mag_a_reg  <= in_mag_a;
            mag_b_reg  <= in_mag_b;
            sign_a_reg <= in_sign_a;
            sign_b_reg <= in_sign_b;
            rem_reg    <= 32'd0;
            quo_reg    <= in_mag_a;
            count_reg  <= 5'd0;
          end
        end
        MUL: begin
          hl_data_reg <= neg_result ? (64'd0 - product) : product;
        end
        DIV: begin
          rem_reg   <= rem_step;
          quo_reg   <= quo_step;
          count_reg <= count_reg + 5'd1;
          if (count_reg == 5'd31) begin
            // A zero divisor leaves the latched dividend as remainder and all-ones quotient.
            if (mag_b_reg == 32'd0)
              hl_data_reg <= {mag_a_reg, 32'hFFFF_FFFF};
            else
              hl_data_reg <= {(sign_a_reg ? (32'd0 - rem_step) : rem_step),
                              (neg_result ? (32'd0 - quo_step) : quo_step)};
          end
        end
        default: ;
      endcase
    end
  end

  assign hl_data = hl_data_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed {hi, lo} results and latencies.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        hl_write_enable;
  logic [63:0] hl_data;

  int errors = 0;
  int checks = 0;
  logic [63:0] last_result;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  muldiv_unit dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .op              (op),
    .src_a           (src_a),
    .src_b           (src_b),
    .flush           (flush),
    .busy            (busy),
    .hl_write_enable (hl_write_enable),
    .hl_data         (hl_data)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports a mismatch.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one operation, then wait (bounded) for its strobe and check the latency,
  // the busy-cycle count, the result, and that the strobe lasts a single cycle.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input int lat);
    int cyc;
    int bcnt;
    bit seen;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    bcnt = busy ? 1 : 0;
    @(posedge clk);
    #1;
    start = 1'b0; src_a = ~a; src_b = ~b;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (hl_write_enable) seen = 1'b1;
      else if (busy) bcnt++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(lat));
    check({tag, " busy cycles"}, 64'(bcnt), 64'(lat));
    check({tag, " data"}, hl_data, exp);
    check({tag, " busy in done"}, 64'(busy), 64'd0);
    $display("op %s a=%h b=%h -> hl_data=%h after %0d cycles", tag, a, b, hl_data, cyc);
    @(negedge clk);
    check({tag, " strobe width"}, 64'(hl_write_enable), 64'd0);
    last_result = exp;
  endtask

  initial begin
    int cyc;
    int strobes;
    bit seen;
    rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset strobe", 64'(hl_write_enable), 64'd0);
    check("reset data", hl_data, 64'd0);
    rst = 1'b0;

    do_op("MULT -2*3",       OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, 2);
    do_op("MULTU fffffffe*3", OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 64'h0000_0002_FFFF_FFFA, 2);
    do_op("MULT 7fffffff^2", OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 2);
    do_op("DIV -7/2",        OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    do_op("DIV 7/-2",        OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33);
    do_op("DIVU 7/2",        OP_DIVU,  32'h0000_0007, 32'h0000_0002, 64'h0000_0001_0000_0003, 33);
    do_op("DIVU x/0",        OP_DIVU,  32'h1234_5678, 32'h0000_0000, 64'h1234_5678_FFFF_FFFF, 33);
    do_op("DIV min/-1",      OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33);

    // Flush a divide in its 10th cycle: busy drops, no strobe ever, result untouched.
    @(negedge clk);
    start = 1'b1; op = OP_DIV; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush busy", 64'(busy), 64'd0);
    strobes = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hl_write_enable) strobes++;
    end
    check("flush strobes", 64'(strobes), 64'd0);
    check("flush data kept", hl_data, last_result);
    $display("op flushed DIV 100/7 -> hl_data=%h strobes=%0d", hl_data, strobes);
    do_op("MULT after flush", OP_MULT, 32'd3, 32'd5, 64'd15, 2);

    // Back-to-back: DIVU request held in the MULTU DONE cycle is accepted at that edge.
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; src_a = 32'd6; src_b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
    #1;
    check("b2b mul strobe", 64'(hl_write_enable), 64'd1);
    check("b2b mul data", hl_data, 64'd42);
    check("b2b busy in done", 64'(busy), 64'd1);
    $display("op MULTU 6*7 -> hl_data=%h, DIVU 100/7 issued in DONE", hl_data);
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (hl_write_enable) seen = 1'b1;
    end
    check("b2b div latency", 64'(cyc), 64'd33);
    check("b2b div data", hl_data, 64'h0000_0002_0000_000E);
    $display("op DIVU 100/7 -> hl_data=%h after %0d cycles", hl_data, cyc);
    last_result = 64'h0000_0002_0000_000E;
    @(negedge clk);

    // start together with flush in IDLE is not accepted.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_MULT; src_a = 32'd9; src_b = 32'd9;
    #1;
    check("start+flush busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (hl_write_enable || busy) strobes++;
    end
    check("start+flush ignored", 64'(strobes), 64'd0);
    check("start+flush data", hl_data, last_result);
    $display("op MULT 9*9 with flush -> not accepted, hl_data=%h", hl_data);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
